// File: rtl/furv_pkg.sv
// -----------------------------------------------------------------------------
// furv_pkg
// Shared definitions for the instruction fetch slice: data width, fetch FSM
// state encoding, default reset fetch address, and a word-alignment helper.
// -----------------------------------------------------------------------------
package furv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // IDLE: free to issue; WAIT: one read outstanding, data wanted;
  // DROP: one read outstanding, data to be thrown away (stale after redirect).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/furv_fifo.sv
// -----------------------------------------------------------------------------
// furv_fifo
// Synchronous FIFO used as the prefetch queue. Head word is visible
// combinationally on o_rdata. Flush empties the queue and wins over push/pop.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_push, i_wdata   write one entry (ignored when full)
//   i_pop             retire head entry (ignored when empty)
//   i_flush           discard all entries
//   o_rdata           head entry
//   o_count           occupancy 0..DEPTH
//   o_full, o_empty   occupancy flags
// -----------------------------------------------------------------------------
module furv_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = i_push && !i_flush && (r_count != FULL_CNT);
  assign w_do_pop  = i_pop  && !i_flush && (r_count != '0);

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction prefetcher: issues word-aligned reads (one outstanding at most),
// buffers returned words with their addresses in a DEPTH-entry queue, and
// discards the prefetched stream on a core redirect.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   mem_req, mem_addr, mem_gnt         request channel to instruction memory
//   mem_rvalid, mem_rdata              response channel
//   redirect, redirect_pc              branch/jump from the core
//   instr_valid, instr, instr_pc       queue head to the core
//   instr_ready                        core consumes the head
// -----------------------------------------------------------------------------
module fetch_unit
  import furv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;

  logic w_mem_req;
  logic w_issue;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic [2*XLEN-1:0] w_head;

  // rst_n gates the request so it drops the moment reset asserts, without
  // waiting for the state register to be cleared by a clock.
  assign w_mem_req = rst_n && (r_state == ST_IDLE) && !redirect && !w_full;
  assign w_issue   = w_mem_req && mem_gnt;
  assign w_pop     = !w_empty && instr_ready && !redirect;

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          w_state_next = ST_IDLE;
          w_push       = !redirect;
        end else if (redirect) begin
          w_state_next = ST_DROP;
        end
      end
      ST_DROP: begin
        // The stale response retires the outstanding read even if another
        // redirect lands in the same cycle; nothing is left to wait for.
        if (mem_rvalid) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= word_align(RESET_PC);
      r_req_pc   <= '0;
    end else begin
      r_state <= w_state_next;
      if (redirect) begin
        r_fetch_pc <= word_align(redirect_pc);
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_issue) r_req_pc <= r_fetch_pc;
    end
  end

  furv_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({r_req_pc, mem_rdata}),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign mem_req     = w_mem_req;
  assign mem_addr    = r_fetch_pc;
  assign instr_valid = (w_count != '0);
  assign instr_pc    = w_head[2*XLEN-1:XLEN];
  assign instr       = w_head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed scenarios plus randomized traffic against a queue-based model of
// the prefetcher. Inputs change at the falling edge; outputs are compared
// 1 ns later, before the next rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: queue of {pc, word}, next fetch address, and whether a read is
  // in flight and whether its data is still wanted.
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  bit          m_out;
  bit          m_drop;
  bit          last_issue;
  int          resp_wait;

  function automatic void model_reset();
    mq.delete();
    m_pc   = RPC;
    m_out  = 1'b0;
    m_drop = 1'b0;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // One clock cycle: drive, compare against model, advance model.
  task automatic step(input bit g, input bit rv, input logic [31:0] rd,
                      input bit rdr, input logic [31:0] rpc, input bit rdy);
    bit          exp_req;
    bit          pop;
    logic [63:0] head;
    @(negedge clk);
    mem_gnt     = g;
    mem_rvalid  = rv;
    mem_rdata   = rd;
    redirect    = rdr;
    redirect_pc = rpc;
    instr_ready = rdy;
    #1;
    exp_req = !m_out && !rdr && (mq.size() < DEPTH);
    check1("mem_req", mem_req, exp_req);
    if (exp_req) check32("mem_addr", mem_addr, m_pc);
    check1("instr_valid", instr_valid, mq.size() != 0);
    head = '0;
    if (mq.size() != 0) begin
      head = mq[0];
      check32("instr_pc", instr_pc, head[63:32]);
      check32("instr", instr, head[31:0]);
    end
    last_issue = exp_req && g;
    pop = (mq.size() != 0) && rdy && !rdr;
    if (rdr) begin
      mq.delete();
    end else if (pop) begin
      void'(mq.pop_front());
      $display("pop pc=%08h instr=%08h", head[63:32], head[31:0]);
    end
    if (m_out && rv) begin
      if (!m_drop && !rdr) mq.push_back({m_req_pc, rd});
      m_out  = 1'b0;
      m_drop = 1'b0;
    end else if (m_out && rdr) begin
      m_drop = 1'b1;
    end
    if (last_issue) begin
      m_out    = 1'b1;
      m_req_pc = m_pc;
      m_pc     = m_pc + 32'd4;
    end
    if (rdr) m_pc = {rpc[31:2], 2'b00};
  endtask

  // Asynchronous reset pulse placed away from both clock edges.
  task automatic do_reset();
    @(negedge clk);
    #2;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_instr_valid", instr_valid, 1'b0);
    check32("rst_mem_addr", mem_addr, RPC);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    resp_wait = 0;
    #2;
    check1("init_mem_req", mem_req, 1'b0);
    check1("init_instr_valid", instr_valid, 1'b0);
    check32("init_mem_addr", mem_addr, RPC);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check1("first_req_after_reset", mem_req, 1'b1);

    // Basic fetch of one word.
    step(1, 0, 32'h0, 0, 32'h0, 1);
    check32("basic_addr0", mem_addr, 32'h0);
    step(0, 1, 32'h0010_0093, 0, 32'h0, 0);
    check1("basic_wait_noreq", mem_req, 1'b0);
    step(0, 0, 32'h0, 0, 32'h0, 1);
    check1("basic_valid", instr_valid, 1'b1);
    check32("basic_pc", instr_pc, 32'h0);
    check32("basic_instr", instr, 32'h0010_0093);
    check32("basic_next_addr", mem_addr, 32'h4);

    // Fill to DEPTH with the core stalled.
    step(0, 0, 32'h0, 1, 32'h0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 32'h0, 0, 32'h0, 0);
      step(0, 1, 32'hA000_0000 + 32'(i), 0, 32'h0, 0);
    end
    step(0, 0, 32'h0, 0, 32'h0, 0);
    check32("full_occ_model", 32'(mq.size()), 32'd4);
    check1("full_noreq", mem_req, 1'b0);
    check32("full_head_pc", instr_pc, 32'h0);
    step(0, 0, 32'h0, 0, 32'h0, 1);
    check1("full_pop_noreq", mem_req, 1'b0);
    step(1, 0, 32'h0, 0, 32'h0, 0);
    check1("after_pop_req", mem_req, 1'b1);
    check32("after_pop_addr", mem_addr, 32'h10);
    check32("after_pop_head", instr_pc, 32'h4);

    // Redirect while waiting: the late word is dropped.
    step(0, 0, 32'h0, 1, 32'h0000_0103, 0);
    step(0, 0, 32'h0, 0, 32'h0, 0);
    check1("drop_empty", instr_valid, 1'b0);
    check1("drop_noreq", mem_req, 1'b0);
    step(0, 1, 32'hDEAD_BEEF, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0, 32'h0, 0);
    check1("drop_still_empty", instr_valid, 1'b0);
    check1("drop_req", mem_req, 1'b1);
    check32("drop_addr", mem_addr, 32'h100);

    // Redirect coinciding with the response.
    step(1, 0, 32'h0, 0, 32'h0, 0);
    step(0, 1, 32'h0000_1234, 1, 32'h0000_0200, 1);
    step(0, 0, 32'h0, 0, 32'h0, 0);
    check1("coinc_empty", instr_valid, 1'b0);
    check1("coinc_req", mem_req, 1'b1);
    check32("coinc_addr", mem_addr, 32'h200);

    // Address wrap.
    step(0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0);
    step(1, 0, 32'h0, 0, 32'h0, 0);
    check32("wrap_addr_hi", mem_addr, 32'hFFFF_FFFC);
    step(0, 1, 32'h0000_0013, 0, 32'h0, 0);
    step(1, 0, 32'h0, 0, 32'h0, 0);
    check32("wrap_addr_lo", mem_addr, 32'h0);
    step(0, 1, 32'h0000_0013, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0, 32'h0, 1);
    check32("wrap_head_pc", instr_pc, 32'hFFFF_FFFC);

    // Reset while a read is outstanding, stray response afterwards.
    step(1, 0, 32'h0, 0, 32'h0, 0);
    do_reset();
    step(0, 1, 32'hBAD0_0001, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0, 32'h0, 0);
    check1("stray_ignored", instr_valid, 1'b0);
    check1("stray_req", mem_req, 1'b1);
    check32("stray_addr", mem_addr, RPC);

    // Randomized traffic with a 1..3 cycle memory.
    resp_wait = 0;
    for (int n = 0; n < 3000; n++) begin
      bit          g, rv, rdr, rdy;
      logic [31:0] rd, rpc;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        if (resp_wait > 0) resp_wait--;
        continue;
      end
      rv  = (resp_wait == 1) || (resp_wait == 0 && !m_out && $urandom_range(0, 9) == 0);
      g   = (resp_wait == 0) && ($urandom_range(0, 9) < 6);
      rdr = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      rdy = $urandom_range(0, 1) == 1;
      rd  = $urandom;
      step(g, rv, rd, rdr, rpc, rdy);
      if (resp_wait > 0) resp_wait--;
      if (last_issue) resp_wait = $urandom_range(1, 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, prefetch queue entries, power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 mem_req  out  1  instruction-memory read request.
REQ-006 mem_addr  out  32  word-aligned fetch address, valid while mem_req=1.
REQ-007 mem_gnt  in  1  request accepted this cycle when mem_req=1.
REQ-008 mem_rvalid  in  1  read data returned this cycle, at least one cycle after grant.
REQ-009 mem_rdata  in  32  instruction word, valid with mem_rvalid.
REQ-010 redirect  in  1  core branch/jump: discard prefetched stream.
REQ-011 redirect_pc  in  32  new fetch target, sampled with redirect.
REQ-012 instr_valid  out  1  queue head holds a valid instruction.
REQ-013 instr  out  32  queue-head instruction word.
REQ-014 instr_pc  out  32  address instr was fetched from.
REQ-015 instr_ready  in  1  core consumes head this cycle.

Function
REQ-016 Internal fetch_pc SHALL drive mem_addr; bits [1:0] SHALL always be 0.
REQ-017 FSM states SHALL be IDLE, WAIT, DROP; at most one memory request outstanding.
REQ-018 mem_req SHALL be 1 iff state=IDLE, redirect=0, and occupancy < DEPTH; mem_req is combinational.
REQ-019 IDLE with mem_req=1 and mem_gnt=1: fetch_pc <= fetch_pc+4 (mod 2^32); state -> WAIT; issued address is recorded as req_pc.
REQ-020 WAIT with mem_rvalid=1 and redirect=0: push {req_pc, mem_rdata}; state -> IDLE; next request no earlier than the following cycle.
REQ-021 instr_valid SHALL equal (occupancy != 0); instr/instr_pc SHALL show the head combinationally.
REQ-022 Pop SHALL occur when instr_valid=1, instr_ready=1, and redirect=0.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged; entry order is preserved.
REQ-024 Full (occupancy=DEPTH): no request is issued; the returning word always has room because REQ-018 gates issue.
REQ-025 Redirect SHALL flush the queue (occupancy <= 0, no pop) and set fetch_pc <= {redirect_pc[31:2],2'b00}.
REQ-026 Redirect in WAIT with mem_rvalid=0: state -> DROP; the next mem_rvalid is discarded and the state goes to IDLE.
REQ-027 Redirect in WAIT with mem_rvalid=1: data discarded; state -> IDLE.
REQ-028 Redirect in DROP: fetch_pc updated; state stays DROP.
REQ-029 Redirect in IDLE: state stays IDLE; the first request to the new target issues the next cycle.
REQ-030 mem_rvalid in IDLE SHALL be ignored.
REQ-031 fetch_pc wrap from 32'hFFFF_FFFC SHALL yield 32'h0000_0000.

Reset
REQ-032 On rst_n=0: state=IDLE, fetch_pc=RESET_PC, occupancy=0, instr_valid=0, mem_req=0; the reset effect is immediate and does not wait for clk.
REQ-033 Reset mid-request SHALL abandon the outstanding read; a late mem_rvalid in IDLE after reset is ignored.
REQ-034 The first mem_req SHALL assert in the first cycle after rst_n deasserts.

Structure
REQ-035 The shared package furv_pkg SHALL hold XLEN=32, the fetch FSM state enum, and RESET_PC default.
REQ-036 The queue SHALL be a sub-module furv_fifo (synchronous, parameterised width/depth, push/pop/flush, occupancy count, full/empty); the FSM and fetch_pc are held in fetch_unit.

Verification
REQ-037 Reset, mem_gnt=1, rvalid 1 cycle after grant with 32'h00100093, instr_ready=1 -> mem_addr=0 first; instr_valid with instr_pc=0, instr=32'h00100093; next fetch address 4.
REQ-038 instr_ready=0, DEPTH=4, zero-latency-plus-one memory -> exactly 4 entries (pc 0,4,8,C); mem_req=0 while full; one pop -> next request to 0x10.
REQ-039 redirect with redirect_pc=32'h0000_0103 during WAIT, rvalid 2 cycles later -> that word is dropped; queue empty; next mem_addr=0x100.
REQ-040 redirect in the same cycle as mem_rvalid and instr_ready=1 -> no push, no pop; occupancy=0; state IDLE.
REQ-041 rst_n pulse low while WAIT, stray rvalid after release -> ignored; mem_addr=RESET_PC; instr_valid=0 until a genuine response arrives.
REQ-042 redirect_pc=32'hFFFF_FFFC with continuous grants -> fetch addresses FFFF_FFFC then 0000_0000.
